// File: rtl/ripple_count_capture_pkg.sv
// Shared defaults and state encoding for the ripple counter capture path.
package ripple_count_capture_pkg;

   // Defaults shared with the ripple counter and display blocks
   localparam int unsigned IN_W_DEF          = 4;
   localparam int unsigned COUNT_W_DEF       = 12;
   localparam int unsigned SYNC_STAGES_DEF   = 2;
   localparam int unsigned STABLE_CYCLES_DEF = 2;
   localparam int unsigned MAX_STEP_DEF      = 8;
   localparam int unsigned THRESH_DEF        = 100;

   // Capture state: waiting for a first settled value, or tracking wraps
   typedef enum logic {
      ST_ACQ   = 1'b0,
      ST_TRACK = 1'b1
   } state_e;

endpackage : ripple_count_capture_pkg

// File: rtl/ripple_count_capture_sync_bus.sv
// Per-bit multi-flop synchronizer for an asynchronous bus.
// syn is the final stage; syn_pre is the stage feeding it, so the consumer
// can see a value that is about to land and compare it against the one held.
module sync_bus #(
   parameter int unsigned W      = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] syn,
   output logic [W-1:0] syn_pre
);

   logic [STAGES-1:0][W-1:0] stage_q;
   logic [STAGES-1:0][W-1:0] stage_d;

   // Shift the raw input one stage deeper each clock
   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = d;
      for (int unsigned i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Synchronizer flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign syn     = stage_q[STAGES-1];
   assign syn_pre = stage_q[STAGES-2];

endmodule : sync_bus

// File: rtl/ripple_count_capture.sv
// Clock-domain consumer of the asynchronous ripple counter: synchronizes,
// accepts only settled values, extends the count across wraps and raises
// threshold / overflow / step-error flags.
module ripple_count_capture
   import ripple_count_capture_pkg::*;
#(
   parameter int unsigned        IN_W          = IN_W_DEF,
   parameter int unsigned        COUNT_W       = COUNT_W_DEF,
   parameter int unsigned        SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int unsigned        STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned        MAX_STEP      = MAX_STEP_DEF,
   parameter logic [COUNT_W-1:0] THRESH        = COUNT_W'(THRESH_DEF)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IN_W-1:0]    cnt_in,
   input  logic               clear,
   output logic               valid,
   output logic [COUNT_W-1:0] count_out,
   output logic               wrap_pulse,
   output logic               thresh_hit,
   output logic               ovf,
   output logic               step_err
);

   localparam int unsigned EXT_W  = COUNT_W - IN_W;
   localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

   logic [IN_W-1:0]   syn;
   logic [IN_W-1:0]   syn_pre;

   logic [STAB_W-1:0] stab_q,     stab_d;
   state_e            state_q,    state_d;
   logic              valid_q,    valid_d;
   logic [EXT_W-1:0]  ext_q,      ext_d;
   logic [IN_W-1:0]   low_q,      low_d;
   logic              wrap_q,     wrap_d;
   logic              thresh_q,   thresh_d;
   logic              ovf_q,      ovf_d;
   logic              step_err_q, step_err_d;

   logic              accept_c;
   logic [IN_W-1:0]   step_c;

   sync_bus #(
      .W      (IN_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .d       (cnt_in),
      .syn     (syn),
      .syn_pre (syn_pre)
   );

   // Settling filter: count consecutive cycles where the incoming synced
   // value matches the held one; accept once when the count saturates
   always_comb begin
      stab_d   = stab_q;
      accept_c = 1'b0;
      if (syn_pre != syn) begin
         stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + STAB_W'(1);
      end
      accept_c = (stab_d == STAB_MAX) && (stab_q != STAB_MAX);
      if (clear) begin
         stab_d   = '0;
         accept_c = 1'b0;
      end
   end

   // Acquire/track FSM with wrap extension and sticky flags
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      ext_d      = ext_q;
      low_d      = low_q;
      wrap_d     = 1'b0;
      ovf_d      = ovf_q;
      step_err_d = step_err_q;
      step_c     = syn - low_q;
      thresh_d   = valid_q && ({ext_q, low_q} >= THRESH);

      if (clear) begin
         state_d    = ST_ACQ;
         valid_d    = 1'b0;
         ext_d      = '0;
         low_d      = '0;
         ovf_d      = 1'b0;
         step_err_d = 1'b0;
         thresh_d   = 1'b0;
      end else if (accept_c) begin
         case (state_q)
            ST_ACQ: begin
               low_d   = syn;
               ext_d   = '0;
               valid_d = 1'b1;
               state_d = ST_TRACK;
            end
            ST_TRACK: begin
               if (syn != low_q) begin
                  low_d = syn;
                  // A lower value means the ripple counter passed all-ones
                  if (syn < low_q) begin
                     wrap_d = 1'b1;
                     ext_d  = ext_q + EXT_W'(1);
                     if (&ext_q) begin
                        ovf_d = 1'b1;
                     end
                  end
                  if (32'(step_c) > MAX_STEP) begin
                     step_err_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_ACQ;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stab_q     <= '0;
         state_q    <= ST_ACQ;
         valid_q    <= 1'b0;
         ext_q      <= '0;
         low_q      <= '0;
         wrap_q     <= 1'b0;
         thresh_q   <= 1'b0;
         ovf_q      <= 1'b0;
         step_err_q <= 1'b0;
      end else begin
         stab_q     <= stab_d;
         state_q    <= state_d;
         valid_q    <= valid_d;
         ext_q      <= ext_d;
         low_q      <= low_d;
         wrap_q     <= wrap_d;
         thresh_q   <= thresh_d;
         ovf_q      <= ovf_d;
         step_err_q <= step_err_d;
      end
   end

   assign valid      = valid_q;
   assign count_out  = {ext_q, low_q};
   assign wrap_pulse = wrap_q;
   assign thresh_hit = thresh_q;
   assign ovf        = ovf_q;
   assign step_err   = step_err_q;

endmodule : ripple_count_capture

// File: tb/tb_ripple_count_capture.sv
// Bench for ripple_count_capture: directed scenarios plus randomized
// hold/step/clear traffic, checked every cycle against a count-level model.
module tb_ripple_count_capture;
   import ripple_count_capture_pkg::*;

   localparam int unsigned S    = SYNC_STAGES_DEF;
   localparam int unsigned ST   = STABLE_CYCLES_DEF;
   localparam int          MODV = 1 << IN_W_DEF;
   localparam int          FULL = 1 << COUNT_W_DEF;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [IN_W_DEF-1:0]    cnt_in;
   logic                   clear;
   logic                   valid;
   logic [COUNT_W_DEF-1:0] count_out;
   logic                   wrap_pulse;
   logic                   thresh_hit;
   logic                   ovf;
   logic                   step_err;

   int n_checks = 0;
   int n_pass   = 0;
   int wrap_cnt = 0;

   // Model: what the clock domain has seen of cnt_in, and the tracked count
   int seen [S];
   int m_stab, m_count;
   bit m_valid, m_wrap, m_thr, m_ovf, m_serr;

   ripple_count_capture dut (
      .clk        (clk),
      .reset      (reset),
      .cnt_in     (cnt_in),
      .clear      (clear),
      .valid      (valid),
      .count_out  (count_out),
      .wrap_pulse (wrap_pulse),
      .thresh_hit (thresh_hit),
      .ovf        (ovf),
      .step_err   (step_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < S; i++) seen[i] = 0;
      m_stab = 0; m_count = 0;
      m_valid = 0; m_wrap = 0; m_thr = 0; m_ovf = 0; m_serr = 0;
   endtask

   // One clock edge of the reference: x and c are the inputs present at the edge
   task automatic model_edge(input int x, input bit c);
      int syn, nstab, low, step, nxt;
      bit nthr;
      syn  = seen[S-1];
      nthr = m_valid && (m_count >= int'(THRESH_DEF));
      m_wrap = 0;
      if (c) begin
         nstab = 0; m_valid = 0; m_count = 0; m_ovf = 0; m_serr = 0; nthr = 0;
      end else begin
         nstab = (seen[S-2] == syn) ? ((m_stab < int'(ST)) ? m_stab + 1 : int'(ST)) : 0;
         if (nstab == int'(ST) && m_stab != int'(ST)) begin
            if (!m_valid) begin
               m_valid = 1;
               m_count = syn;
            end else begin
               low = m_count % MODV;
               if (syn != low) begin
                  step = (syn - low + MODV) % MODV;
                  nxt  = m_count + step;
                  if (step > int'(MAX_STEP_DEF)) m_serr = 1;
                  if (syn < low) m_wrap = 1;
                  if (nxt >= FULL) m_ovf = 1;
                  m_count = nxt % FULL;
               end
            end
         end
      end
      m_stab = nstab;
      m_thr  = nthr;
      for (int i = S - 1; i > 0; i--) seen[i] = seen[i-1];
      seen[0] = x;
   endtask

   task automatic compare_all();
      chk("valid",      int'(valid),      int'(m_valid));
      chk("count_out",  int'(count_out),  m_count);
      chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
      chk("thresh_hit", int'(thresh_hit), int'(m_thr));
      chk("ovf",        int'(ovf),        int'(m_ovf));
      chk("step_err",   int'(step_err),   int'(m_serr));
   endtask

   task automatic tick();
      int x;
      bit c;
      x = int'(cnt_in);
      c = clear;
      @(posedge clk);
      model_edge(x, c);
      #1;
      if (wrap_pulse) wrap_cnt++;
      compare_all();
   endtask

   task automatic hold(input int v, input int n);
      cnt_in = IN_W_DEF'(v);
      repeat (n) tick();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      int last, v;
      reset  = 1'b0;
      clear  = 1'b0;
      cnt_in = IN_W_DEF'(3);
      model_reset();
      #2;
      chk("reset_valid", int'(valid), 0);
      chk("reset_count", int'(count_out), 0);
      #10;
      reset = 1'b1;

      // First settled value appears after sync + filter latency
      tick(); tick(); tick();
      chk("t1_valid_early", int'(valid), 0);
      tick();
      chk("t1_valid", int'(valid), 1);
      chk("t1_count", int'(count_out), 3);
      chk("t1_wrap", int'(wrap_pulse), 0);

      // Walk up to 15 and wrap to 0
      for (int k = 4; k < 16; k++) hold(k, 6);
      wrap_cnt = 0;
      hold(0, 6);
      chk("t2_count", int'(count_out), 16);
      chk("t2_wrap_once", wrap_cnt, 1);
      chk("t2_step_err", int'(step_err), 0);

      // A one-cycle glitch must not be accepted
      hold(5, 6);
      hold(7, 1);
      hold(6, 6);
      chk("t3_count", int'(count_out), 22);

      // Oversized jump, then clear and re-acquire
      pulse_clear();
      hold(2, 6);
      chk("t4_seed", int'(count_out), 2);
      hold(12, 6);
      chk("t4_step_err", int'(step_err), 1);
      chk("t4_count", int'(count_out), 12);
      hold(12, 4);
      chk("t4_sticky", int'(step_err), 1);
      pulse_clear();
      chk("t4_clr_valid", int'(valid), 0);
      chk("t4_clr_step_err", int'(step_err), 0);
      hold(12, 6);
      chk("t4_reacq", int'(count_out), 12);

      // Threshold at 100, then run the extension up to overflow
      pulse_clear();
      hold(0, 6);
      for (int k = 0; k < 6; k++) begin
         hold(8, 4);
         hold(0, 4);
      end
      cnt_in = IN_W_DEF'(4);
      for (int k = 0; k < 10 && m_count != 100; k++) tick();
      chk("t5_count100", int'(count_out), 100);
      chk("t5_thresh_lag", int'(thresh_hit), 0);
      tick();
      chk("t5_thresh", int'(thresh_hit), 1);
      for (int k = 0; k < 300 && m_count != FULL - MODV; k++) begin
         hold(8, 4);
         hold(0, 4);
      end
      hold(15, 4);
      chk("t5_max", int'(count_out), FULL - 1);
      chk("t5_no_ovf", int'(ovf), 0);
      hold(0, 4);
      chk("t5_wrap_zero", int'(count_out), 0);
      chk("t5_ovf", int'(ovf), 1);

      // Randomized hold/step/clear traffic
      last = 0;
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 19) == 0) pulse_clear();
         v = (last + int'($urandom_range(0, 10))) % MODV;
         hold(v, int'($urandom_range(1, 6)));
         last = v;
      end

      // Reset while a new value is half-way through the filter
      hold((last + 3) % MODV, 2);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_valid", int'(valid), 0);
      chk("t6_rst_count", int'(count_out), 0);
      chk("t6_rst_wrap", int'(wrap_pulse), 0);
      chk("t6_rst_thresh", int'(thresh_hit), 0);
      chk("t6_rst_ovf", int'(ovf), 0);
      chk("t6_rst_step_err", int'(step_err), 0);
      model_reset();
      cnt_in = IN_W_DEF'(9);
      #1;
      reset = 1'b1;
      tick(); tick(); tick();
      chk("t6_valid_early", int'(valid), 0);
      tick();
      chk("t6_valid", int'(valid), 1);
      chk("t6_count", int'(count_out), 9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_ripple_count_capture
